// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM state encoding,
// the row/column to hex key map and small row-decoding helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        LOCK    = 2'd1,
        RELEASE = 2'd2
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b0001;

    // Indexed KEY_MAP[row][col]; the leftmost group is row 3, the rightmost nibble of a group is col 0.
    localparam logic [3:0][3:0][3:0] KEY_MAP = {
        {4'hD, 4'hF, 4'h0, 4'hE},
        {4'hC, 4'h9, 4'h8, 4'h7},
        {4'hB, 4'h6, 4'h5, 4'h4},
        {4'hA, 4'h3, 4'h2, 4'h1}
    };

    function automatic logic [1:0] first_row(input logic [3:0] rows);
        if (rows[0])      return 2'd0;
        else if (rows[1]) return 2'd1;
        else if (rows[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    function automatic logic multi_row(input logic [3:0] rows);
        return (rows & (rows - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: raw rows in, column drive plus synchronised rows and locked key out.
interface keypad_scanner_if;
    logic [3:0] row_raw;
    logic [3:0] col;
    logic [3:0] q_row_keys;
    logic [3:0] hex_R_out;
    logic       key_valid;

    modport master (
        output row_raw,
        input  col,
        input  q_row_keys,
        input  hex_R_out,
        input  key_valid
    );

    modport slave (
        input  row_raw,
        output col,
        output q_row_keys,
        output hex_R_out,
        output key_valid
    );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for the asynchronous keypad row lines; reset clears both stages.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: one-hot column drive, row synchronisation, lock on key and quiet-dwell release.
// Optional build macro MULTI_KEY_REJECT_EN: ignore a column whose rows show more than one pressed key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1200
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.slave  kp
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(SCAN_DIV - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       hex_q, hex_d;
    logic             key_valid_q, key_valid_d;

    logic [3:0]       rows;
    logic             term;
    logic             key_seen;
    logic [1:0]       row_idx;

    sync_2ff #(.W(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row_raw),
        .q     (rows)
    );

    assign term    = (cnt_q == TERM_VAL);
    assign row_idx = first_row(rows);

`ifdef MULTI_KEY_REJECT_EN
    assign key_seen = (rows != 4'd0) && !multi_row(rows);
`else
    assign key_seen = (rows != 4'd0);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        hex_d     = hex_q;

        unique case (state_q)
            SCAN: begin
                if (term) begin
                    cnt_d = '0;
                    if (key_seen) begin
                        state_d = LOCK;
                        hex_d   = KEY_MAP[row_idx][col_idx_q];
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        col_d     = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCK: begin
                cnt_d = '0;
                if (rows == 4'd0) state_d = RELEASE;
            end
            RELEASE: begin
                // Any row activity during the quiet dwell re-locks without relatching the key code.
                if (rows != 4'd0) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end else if (term) begin
                    state_d   = SCAN;
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    col_d     = {col_q[2:0], col_q[3]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

        key_valid_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= COL_RESET;
            hex_q       <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            hex_q       <= hex_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.col        = col_q;
    assign kp.q_row_keys = rows;
    assign kp.hex_R_out  = hex_q;
    assign kp.key_valid  = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8; a key is modelled as a row driven only while its column is active.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] key_col, key_rows, row_force;

    always #5 clk = ~clk;

    keypad_scanner_if kp_if ();

    assign kp_if.row_raw = row_force | ((kp_if.col == key_col) ? key_rows : 4'b0000);

    keypad_scanner #(.SCAN_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic wait_col(input string tag, input int max, output int cyc);
        logic [3:0] c0;
        c0 = kp_if.col;
        cyc = 0;
        while (kp_if.col === c0 && cyc < max) begin
            tick(1);
            cyc++;
        end
        check({tag, "_timeout"}, 8'(kp_if.col !== c0), 8'd1);
    endtask

    task automatic wait_kv(input string tag, input logic v, input int max, output int cyc);
        cyc = 0;
        while (kp_if.key_valid !== v && cyc < max) begin
            tick(1);
            cyc++;
        end
        check({tag, "_timeout"}, 8'(kp_if.key_valid), 8'(v));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset     = 1'b1;
        key_col   = 4'b0000;
        key_rows  = 4'b0000;
        row_force = 4'b0000;
        tick(3);
        reset = 1'b0;

        check("rst_col", 8'(kp_if.col), 8'h01);
        check("rst_kv", 8'(kp_if.key_valid), 8'h00);
        check("rst_hex", 8'(kp_if.hex_R_out), 8'h00);
        check("rst_rows", 8'(kp_if.q_row_keys), 8'h00);

        // Idle rotation: one column step every 8 clocks, wrapping back to col 0.
        push(8'h02); push(8'h04); push(8'h08); push(8'h01);
        for (int i = 0; i < 4; i++) begin
            wait_col("rot", 20, cyc);
            pop_check("rot_col", 8'(kp_if.col));
            check("rot_dwell", 8'(cyc), 8'd8);
            check("rot_kv", 8'(kp_if.key_valid), 8'h00);
        end

        // Key at row 1 / col 2 -> '6'; lock lands one edge after the col-2 term.
        key_col  = 4'b0100;
        key_rows = 4'b0010;
        push(8'h06);
        wait_kv("lock", 1'b1, 40, cyc);
        check("lock_latency", 8'(cyc), 8'd24);
        pop_check("lock_hex", 8'(kp_if.hex_R_out));
        check("lock_col", 8'(kp_if.col), 8'h04);
        check("lock_rows", 8'(kp_if.q_row_keys), 8'h02);

        // Release: two synchroniser clocks then one to leave LOCK.
        key_rows = 4'b0000;
        wait_kv("rel", 1'b0, 10, cyc);
        check("rel_latency", 8'(cyc), 8'd3);
        check("rel_col", 8'(kp_if.col), 8'h04);

        // Bounce back within the quiet dwell: relock, code not relatched.
        tick(3);
        key_rows = 4'b0010;
        push(8'h06);
        wait_kv("relock", 1'b1, 10, cyc);
        check("relock_latency", 8'(cyc), 8'd3);
        pop_check("relock_hex", 8'(kp_if.hex_R_out));
        check("relock_col", 8'(kp_if.col), 8'h04);

        // Full release: quiet dwell completes and scanning resumes at the next column.
        key_rows = 4'b0000;
        key_col  = 4'b0000;
        push(8'h08);
        wait_col("resume", 20, cyc);
        pop_check("resume_col", 8'(kp_if.col));
        check("resume_dwell", 8'(cyc), 8'd11);
        check("resume_kv", 8'(kp_if.key_valid), 8'h00);
        check("resume_hex", 8'(kp_if.hex_R_out), 8'h06);

        // Short mid-dwell pulse: visible on the synchronised rows, gone before term.
        tick(2);
        row_force = 4'b0001;
        tick(1);
        check("sync_delay1", 8'(kp_if.q_row_keys), 8'h00);
        tick(1);
        check("sync_delay2", 8'(kp_if.q_row_keys), 8'h01);
        row_force = 4'b0000;
        push(8'h01);
        wait_col("pulse", 20, cyc);
        pop_check("pulse_col", 8'(kp_if.col));
        check("pulse_kv", 8'(kp_if.key_valid), 8'h00);
        check("pulse_hex", 8'(kp_if.hex_R_out), 8'h06);

        // Two rows pressed on col 0.
        key_col  = 4'b0001;
        key_rows = 4'b1001;
`ifdef MULTI_KEY_REJECT_EN
        push(8'h02);
        wait_col("multi", 20, cyc);
        pop_check("multi_col", 8'(kp_if.col));
        check("multi_kv", 8'(kp_if.key_valid), 8'h00);
        check("multi_hex", 8'(kp_if.hex_R_out), 8'h06);
        key_col  = 4'b0010;
        key_rows = 4'b0001;
        push(8'h02);
        wait_kv("single", 1'b1, 20, cyc);
        pop_check("single_hex", 8'(kp_if.hex_R_out));
        check("single_col", 8'(kp_if.col), 8'h02);
`else
        push(8'h01);
        wait_kv("multi", 1'b1, 20, cyc);
        check("multi_latency", 8'(cyc), 8'd8);
        pop_check("multi_hex", 8'(kp_if.hex_R_out));
        check("multi_rows", 8'(kp_if.q_row_keys), 8'h09);
        check("multi_col", 8'(kp_if.col), 8'h01);
`endif

        // One-clock reset while locked with the key still held.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_col", 8'(kp_if.col), 8'h01);
        check("mid_rst_kv", 8'(kp_if.key_valid), 8'h00);
        check("mid_rst_hex", 8'(kp_if.hex_R_out), 8'h00);
        check("mid_rst_rows", 8'(kp_if.q_row_keys), 8'h00);
        check("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
